// File: rtl/store_monitor_pkg.sv
// Shared types and default constants for the store monitor.
// Holds the monitor state encoding, the trace entry layout and the
// default magic addresses/data used by the self-test harness.
package store_monitor_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  localparam logic [31:0] DEF_PASS_ADDR    = 32'd84;
  localparam logic [31:0] DEF_PASS_DATA    = 32'd7;
  localparam logic [31:0] DEF_SCRATCH_ADDR = 32'd80;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with registered storage and an occupancy count one bit wider than the pointers.
// Latency: an entry written at an edge is presented at the head in the following cycle.
// Backpressure: in_rdy drops only when full and no pop happens in the same cycle; pops on empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  // A simultaneous pop frees the slot the push needs, so full only blocks a lone push.
  assign out_vld = (count != '0);
  assign pop     = out_vld && out_rdy;
  assign in_rdy  = (count != FULL_CNT) || pop;
  assign push    = in_vld && in_rdy;
  assign out_dat = mem[rd_ptr];

  // Data array write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_dat;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/store_monitor.sv
// Watches processor stores, records them in a trace FIFO and decides pass/fail from the terminating store.
// Latency: verdict updates at the store edge; a trace entry is visible one cycle after its store when the FIFO was empty.
// Backpressure: out_ready pops the trace; a store arriving with the FIFO full and no pop is dropped and counted.
module store_monitor
  import store_monitor_pkg::*;
#(
  parameter int          DEPTH        = 8,
  parameter logic [31:0] PASS_ADDR    = DEF_PASS_ADDR,
  parameter logic [31:0] PASS_DATA    = DEF_PASS_DATA,
  parameter logic [31:0] SCRATCH_ADDR = DEF_SCRATCH_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic        done,
  output logic        pass,
  output logic [15:0] store_count,
  output logic [7:0]  drop_count
);

  state_t state;
  state_t state_nxt;
  logic   store_vld;
  logic   store_rdy;
  entry_t in_entry;
  entry_t head;

  // Stores only count while the verdict is still open.
  assign store_vld = memwrite && (state == RUN);
  assign in_entry  = '{addr: dataadr, data: writedata};

  sync_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .in_vld (store_vld),
    .in_rdy (store_rdy),
    .in_dat (in_entry),
    .out_vld(out_valid),
    .out_rdy(out_ready),
    .out_dat(head)
  );

  assign out_addr = head.addr;
  assign out_data = head.data;
  assign done     = (state != RUN);
  assign pass     = (state == PASS);

  // Verdict: the pass address ends the run; any address outside the two legal ones fails it.
  always_comb begin
    state_nxt = state;
    if (store_vld) begin
      if (dataadr == PASS_ADDR) begin
        state_nxt = (writedata == PASS_DATA) ? PASS : FAIL;
      end else if (dataadr != SCRATCH_ADDR) begin
        state_nxt = FAIL;
      end
    end
  end

  // Verdict register; PASS and FAIL hold until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Store counter wraps; drop counter saturates so a long overflow stays visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      store_count <= '0;
      drop_count  <= '0;
    end else if (store_vld) begin
      store_count <= store_count + 16'd1;
      if (!store_rdy && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_store_monitor.sv
// Scoreboard bench for store_monitor: a queue-based reference model tracks expected trace and verdict.
// Inputs change 2 time units after each rising edge; outputs are compared on the falling edge.
// The model decides pops from out_ready and its own queue, never from DUT state.
module tb_store_monitor;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic        done;
  logic        pass;
  logic [15:0] store_count;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  store_monitor #(
    .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .memwrite   (memwrite),
    .dataadr    (dataadr),
    .writedata  (writedata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .done       (done),
    .pass       (pass),
    .store_count(store_count),
    .drop_count (drop_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [63:0] exp_q[$];
  bit          m_done = 0;
  bit          m_pass = 0;
  int          m_stores = 0;
  int          m_drops = 0;
  bit          pop_pending = 0;
  bit          started = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on the rising edge, scoreboard comparison on the falling edge.
  always begin
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      m_done   = 0;
      m_pass   = 0;
      m_stores = 0;
      m_drops  = 0;
      started  = 1;
    end else if (!m_done && memwrite) begin
      m_stores = (m_stores + 1) % 65536;
      if ((exp_q.size() + int'(pop_pending) < DEPTH) || pop_pending)
        exp_q.push_back({dataadr, writedata});
      else if (m_drops < 255)
        m_drops++;
      if (dataadr == 32'd84) begin
        m_done = 1;
        m_pass = (writedata == 32'd7);
      end else if (dataadr != 32'd80) begin
        m_done = 1;
      end
    end
    pop_pending = 0;

    @(negedge clk);
    if (started) begin
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check("done", 64'(done), 64'(m_done));
      check("pass", 64'(pass), 64'(m_pass));
      check("store_count", 64'(store_count), 64'(m_stores));
      check("drop_count", 64'(drop_count), 64'(m_drops));
      if (!reset && out_ready && exp_q.size() > 0) begin
        check("trace_head", {out_addr, out_data}, exp_q[0]);
        void'(exp_q.pop_front());
        pop_pending = 1;
      end
    end
  end

  task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d);
    memwrite  = mw;
    dataadr   = a;
    writedata = d;
    @(posedge clk);
    #2;
    memwrite = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 64 && out_valid; i++) begin
      @(posedge clk);
      #2;
    end
    check("drain_empty", 64'(out_valid), 64'(0));
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int r;

    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_store_count", 64'(store_count), 64'(0));

    // Passing program: two scratch stores then the pass store
    out_ready = 1'b0;
    step(1'b1, 32'd80, 32'd5);
    step(1'b1, 32'd80, 32'd6);
    step(1'b1, 32'd84, 32'd7);
    check("pass_done", 64'(done), 64'(1));
    check("pass_pass", 64'(pass), 64'(1));
    check("pass_count", 64'(store_count), 64'(3));
    check("pass_head", {out_addr, out_data}, {32'd80, 32'd5});
    drain();

    // Wrong data at pass address fails; later stores ignored
    do_reset();
    step(1'b1, 32'd84, 32'd3);
    check("fail_done", 64'(done), 64'(1));
    check("fail_pass", 64'(pass), 64'(0));
    step(1'b1, 32'd84, 32'd7);
    check("fail_sticky_count", 64'(store_count), 64'(1));
    check("fail_sticky_pass", 64'(pass), 64'(0));
    drain();

    // Illegal address fails
    do_reset();
    step(1'b1, 32'd88, 32'd7);
    check("illegal_done", 64'(done), 64'(1));
    check("illegal_head", {out_addr, out_data}, {32'd88, 32'd7});
    drain();

    // Overflow: ten stores into an eight-entry trace
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 32'd80, $urandom);
    check("ovf_drop", 64'(drop_count), 64'(2));
    check("ovf_store", 64'(store_count), 64'(10));
    out_ready = 1'b1;
    step(1'b1, 32'd80, 32'hA5A5_0001);
    out_ready = 1'b0;
    check("full_pushpop_drop", 64'(drop_count), 64'(2));
    check("full_pushpop_store", 64'(store_count), 64'(11));
    drain();

    // Drop counter saturation
    do_reset();
    for (int i = 0; i < DEPTH + 260; i++) step(1'b1, 32'd80, 32'(i));
    check("drop_saturate", 64'(drop_count), 64'(255));
    drain();

    // Reset mid-run discards trace and dominates a simultaneous store and pop
    do_reset();
    step(1'b1, 32'd80, 32'd1);
    step(1'b1, 32'd80, 32'd2);
    step(1'b1, 32'd80, 32'd3);
    reset = 1'b1;
    out_ready = 1'b1;
    step(1'b1, 32'd84, 32'd7);
    reset = 1'b0;
    out_ready = 1'b0;
    check("midrst_valid", 64'(out_valid), 64'(0));
    check("midrst_store", 64'(store_count), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    step(1'b1, 32'd84, 32'd7);
    check("after_rst_pass", 64'(pass), 64'(1));
    drain();

    // Randomized traffic with occasional resets
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        out_ready = 1'($urandom_range(0, 1));
        reset = ($urandom_range(0, 39) == 0);
        r = $urandom_range(0, 99);
        if (r < 90)      a = 32'd80;
        else if (r < 96) a = 32'd84;
        else             a = 32'd88 + 32'($urandom_range(0, 15)) * 4;
        d = ($urandom_range(0, 1) == 1) ? 32'd7 : 32'($urandom_range(0, 31));
        step(($urandom_range(0, 3) != 0), a, d);
        reset = 1'b0;
      end
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
